// File: rtl/red_pkg.sv
// rtl/red_pkg.sv - shared state encoding, widths and helpers for the RED byte-reduction unit
package red_pkg;

  localparam int NIB_W   = 4;   // width of one slice operand
  localparam int SUM9_W  = 9;   // signed byte-pair sum
  localparam int TOT_W   = 10;  // signed total of both byte-pair sums
  localparam int RED_LAT = 8;   // cycles from the start cycle to the done cycle

  typedef enum logic [3:0] {
    IDLE,
    LO0,
    LO1,
    HI0,
    HI1,
    CB0,
    CB1,
    CB2,
    DONE
  } red_state_t;

  function automatic logic [15:0] sext16(input logic [TOT_W-1:0] v);
    return {{(16-TOT_W){v[TOT_W-1]}}, v};
  endfunction

endpackage

// File: rtl/red_nibble_slice.sv
// rtl/red_nibble_slice.sv - combinational 4-bit unsigned adder slice with carry-in
// Ports:
//   a, b : nibble operands
//   cin  : carry in
//   sum  : {cout, sum[3:0]}
module red_nibble_slice
  import red_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/red_nibble_seq.sv
// rtl/red_nibble_seq.sv - multi-cycle byte-reduction execute unit built on one nibble adder slice
// Optional macro RED_FLAGS_EN adds the registered flag_z / flag_n outputs.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, only honoured in IDLE
//   flush          : abort to IDLE without done
//   op_a, op_b     : operands captured on an accepted start
//   busy           : high in every non-IDLE state
//   done           : one-cycle pulse while result is valid
//   result         : sext16 of the reduced sum, held until the next done
//   flag_z, flag_n : zero / negative of result (RED_FLAGS_EN only)
module red_nibble_seq
  import red_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
`ifdef RED_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  output logic [DATA_W-1:0] result
);

  if (DATA_W != 16) begin : g_bad_width
    $error("red_nibble_seq supports only DATA_W = 16");
  end

  red_state_t        state, nxt;
  logic [15:0]       a_q, b_q;
  logic              carry;
  logic [SUM9_W-1:0] sum_lo, sum_hi;
  logic [7:0]        tot_lo;

  logic [NIB_W-1:0]  sl_a, sl_b;
  logic              sl_cin;
  logic [NIB_W:0]    sl_sum;
  logic [11:0]       ext_lo, ext_hi;
  logic [TOT_W-1:0]  total;

  red_nibble_slice u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (sl_cin),
    .sum (sl_sum)
  );

  assign ext_lo = {{(12-SUM9_W){sum_lo[SUM9_W-1]}}, sum_lo};
  assign ext_hi = {{(12-SUM9_W){sum_hi[SUM9_W-1]}}, sum_hi};
  // Only valid in CB2: top two bits come straight from the slice.
  assign total  = {sl_sum[1:0], tot_lo};

  // Operand steering into the shared slice.
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_cin = carry;
    case (state)
      LO0: begin sl_a = a_q[3:0];     sl_b = b_q[3:0];     end
      LO1: begin sl_a = a_q[7:4];     sl_b = b_q[7:4];     end
      HI0: begin sl_a = a_q[11:8];    sl_b = b_q[11:8];    end
      HI1: begin sl_a = a_q[15:12];   sl_b = b_q[15:12];   end
      CB0: begin sl_a = ext_lo[3:0];  sl_b = ext_hi[3:0];  sl_cin = 1'b0; end
      CB1: begin sl_a = ext_lo[7:4];  sl_b = ext_hi[7:4];  end
      CB2: begin sl_a = ext_lo[11:8]; sl_b = ext_hi[11:8]; end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LO0;
      LO0:     nxt = LO1;
      LO1:     nxt = HI0;
      HI0:     nxt = HI1;
      HI1:     nxt = CB0;
      CB0:     nxt = CB1;
      CB1:     nxt = CB2;
      CB2:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Datapath; a flush freezes everything so result keeps its last completed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      sum_lo <= '0;
      sum_hi <= '0;
      tot_lo <= '0;
      result <= '0;
`ifdef RED_FLAGS_EN
      flag_z <= 1'b0;
      flag_n <= 1'b0;
`endif
    end else if (!flush) begin
      case (state)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          carry <= 1'b0;
        end
        LO0: begin sum_lo[3:0] <= sl_sum[3:0]; carry <= sl_sum[4]; end
        // Bit 8 of the signed 9-bit sum: sign bits xor the final carry.
        LO1: begin
          sum_lo[8:4] <= {a_q[7] ^ b_q[7] ^ sl_sum[4], sl_sum[3:0]};
          carry       <= 1'b0;
        end
        HI0: begin sum_hi[3:0] <= sl_sum[3:0]; carry <= sl_sum[4]; end
        HI1: begin
          sum_hi[8:4] <= {a_q[15] ^ b_q[15] ^ sl_sum[4], sl_sum[3:0]};
          carry       <= 1'b0;
        end
        CB0: begin tot_lo[3:0] <= sl_sum[3:0]; carry <= sl_sum[4]; end
        CB1: begin tot_lo[7:4] <= sl_sum[3:0]; carry <= sl_sum[4]; end
        CB2: begin
          result <= sext16(total);
`ifdef RED_FLAGS_EN
          flag_z <= (total == '0);
          flag_n <= total[TOT_W-1];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_red_nibble_seq.sv
// tb/tb_red_nibble_seq.sv - self-checking bench for red_nibble_seq
module tb_red_nibble_seq;
  import red_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy, done;
  logic [15:0] result;
`ifdef RED_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  red_nibble_seq #(.DATA_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
`ifdef RED_FLAGS_EN
    .flag_z (flag_z),
    .flag_n (flag_n),
`endif
    .result (result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed byte sums computed with plain integer arithmetic.
  function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a[15:8])) + int'($signed(b[15:8]))
      + int'($signed(a[7:0]))  + int'($signed(b[7:0]));
    return s[15:0];
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string tag);
    int n;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, RED_LAT - 1);
    chk({tag, " result"}, result, exp);
    chk({tag, " busy_in_done"}, busy, 1);
`ifdef RED_FLAGS_EN
    chk({tag, " flag_z"}, flag_z, (exp == 16'h0000));
    chk({tag, " flag_n"}, flag_n, exp[15]);
`endif
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " idle_after"}, busy, 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, acc;
    logic prev_busy;
    logic [15:0] ra, rb;

    tbl[0] = '{16'h0102, 16'h0304, 16'h000A};
    tbl[1] = '{16'h8080, 16'h8080, 16'hFE00};
    tbl[2] = '{16'h7F7F, 16'h7F7F, 16'h01FC};
    tbl[3] = '{16'h01FF, 16'h0000, 16'h0000};
    tbl[4] = '{16'hFF01, 16'h0001, 16'h0001};
    tbl[5] = '{16'h80FF, 16'h7F01, 16'hFFFF};

    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 16'h0000);
`ifdef RED_FLAGS_EN
    chk("reset flag_z", flag_z, 0);
    chk("reset flag_n", flag_n, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    // Flush in HI0: no done, result keeps 0xFFFF from the last vector.
    @(negedge clk);
    op_a = 16'h0102; op_b = 16'h0304; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush result_held", result, 16'hFFFF);
    repeat (10) @(negedge clk);
    chk("flush no_done", done_cnt - d0, 0);
    run_op(16'h0102, 16'h0304, 16'h000A, "after_flush");

    // Flush with start in IDLE drops the start.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("idle_flush no_done", done_cnt - d0, 0);

    // start held high: one done per accepted start, none queued.
    d0 = done_cnt;
    acc = 0;
    prev_busy = busy;
    @(negedge clk);
    op_a = 16'h7F7F; op_b = 16'h7F7F; start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 19) start = 1'b0;
      if (busy && !prev_busy) acc++;
      prev_busy = busy;
    end
    chk("held_start accepts", acc, 3);
    chk("held_start dones", done_cnt - d0, acc);
    chk("held_start result", result, 16'h01FC);

    // Asynchronous reset in CB1 discards the operation.
    d0 = done_cnt;
    @(negedge clk);
    op_a = 16'h0102; op_b = 16'h0304; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset busy", busy, 0);
    chk("async_reset done", done, 0);
    chk("async_reset result", result, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("reset no_done", done_cnt - d0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, ref_red(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
